// File: rtl/rgb_timing_gen.sv
// rgb_timing_gen: lock-gated video raster generator with pixel requests and a 2-cycle LCD output pipeline
module rgb_timing_gen #(
   parameter int H_ACTIVE  = 1280,
   parameter int H_FP      = 110,
   parameter int H_SYNC    = 40,
   parameter int H_BP      = 220,
   parameter int V_ACTIVE  = 720,
   parameter int V_FP      = 5,
   parameter int V_SYNC    = 5,
   parameter int V_BP      = 20,
   parameter bit HSYNC_POL = 1,
   parameter bit VSYNC_POL = 1,
   parameter int LOCK_WAIT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pll_lock,
   output logic        req_valid,
   output logic [10:0] req_x,
   output logic [9:0]  req_y,
   output logic        frame_start,
   input  logic [23:0] pixel_rgb,
   output logic        lcd_de,
   output logic        lcd_hsync,
   output logic        lcd_vsync,
   output logic [23:0] lcd_rgb
);
   localparam int WW = $clog2(LOCK_WAIT + 1);
   localparam logic [10:0] HA  = 11'(H_ACTIVE);
   localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] HT1 = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]  VA  = 10'(V_ACTIVE);
   localparam logic [9:0]  VS0 = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]  VT1 = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [WW-1:0] LW1 = WW'(LOCK_WAIT - 1);

   typedef enum logic {WAIT_LOCK, RUN} state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [10:0]   h_q, h_d;
   logic [9:0]    v_q, v_d;
   logic [1:0]    de_q, de_d, hs_q, hs_d, vs_q, vs_d;
   logic [23:0]   rgb_q, rgb_d;
   logic          lock_s, run, hs_raw, vs_raw;

   // state register, lock synchronizer and output delay line
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= WAIT_LOCK;
         sync_q  <= '0;
         wait_q  <= '0;
         h_q     <= '0;
         v_q     <= '0;
         de_q    <= '0;
         hs_q    <= '0;
         vs_q    <= '0;
         rgb_q   <= '0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         wait_q  <= wait_d;
         h_q     <= h_d;
         v_q     <= v_d;
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         rgb_q   <= rgb_d;
      end
   end

   // lock qualification and raster counters; scan restarts from 0,0 whenever lock is lost
   always_comb begin
      lock_s  = sync_q[1];
      sync_d  = {sync_q[0], pll_lock};
      state_d = state_q;
      wait_d  = wait_q;
      h_d     = h_q;
      v_d     = v_q;
      if (state_q == WAIT_LOCK) begin
         h_d    = '0;
         v_d    = '0;
         wait_d = lock_s ? wait_q + WW'(1) : '0;
         if (lock_s && wait_q == LW1) begin
            state_d = RUN;
            wait_d  = '0;
         end
      end else if (!lock_s) begin
         state_d = WAIT_LOCK;
         wait_d  = '0;
         h_d     = '0;
         v_d     = '0;
      end else begin
         h_d = (h_q == HT1) ? '0 : h_q + 11'd1;
         v_d = (h_q != HT1) ? v_q : (v_q == VT1) ? '0 : v_q + 10'd1;
      end
   end

   // request decode and the two-stage delay that aligns syncs/de with returned pixels
   always_comb begin
      run         = state_q == RUN;
      req_valid   = run && h_q < HA && v_q < VA;
      req_x       = req_valid ? h_q : '0;
      req_y       = req_valid ? v_q : '0;
      frame_start = run && h_q == '0 && v_q == '0;
      hs_raw      = run && h_q >= HS0 && h_q < HS1;
      vs_raw      = run && v_q >= VS0 && v_q < VS1;
      de_d        = {de_q[0], req_valid};
      hs_d        = {hs_q[0], hs_raw};
      vs_d        = {vs_q[0], vs_raw};
      rgb_d       = de_q[0] ? pixel_rgb : '0;
      lcd_de      = de_q[1];
      lcd_hsync   = hs_q[1] ? HSYNC_POL : !HSYNC_POL;
      lcd_vsync   = vs_q[1] ? VSYNC_POL : !VSYNC_POL;
      lcd_rgb     = rgb_q;
   end
endmodule

// File: tb/tb_rgb_timing_gen.sv
// tb_rgb_timing_gen: randomized lock/reset stimulus checked against a frame-position reference model
module tb_rgb_timing_gen;
   localparam int HA = 8, HF = 2, HS = 2, HB = 2;
   localparam int VA = 4, VF = 1, VS = 1, VB = 1;
   localparam int LW = 4;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FR = HT * VT;
   localparam bit HP = 0, VP = 0;

   logic        clk = 0, reset = 1, pll_lock = 0;
   logic [23:0] pixel_rgb = '0;
   logic        req_valid, frame_start, lcd_de, lcd_hsync, lcd_vsync;
   logic [10:0] req_x;
   logic [9:0]  req_y;
   logic [23:0] lcd_rgb;
   logic [49:0] dut_vec;
   localparam logic [49:0] RST_VEC = {1'b0, 11'd0, 10'd0, 1'b0, 1'b0, !HP, !VP, 24'd0};

   always #5 clk = ~clk;

   rgb_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(HP), .VSYNC_POL(VP), .LOCK_WAIT(LW)
   ) dut (
      .clk(clk), .reset(reset), .pll_lock(pll_lock),
      .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .frame_start(frame_start),
      .pixel_rgb(pixel_rgb), .lcd_de(lcd_de), .lcd_hsync(lcd_hsync),
      .lcd_vsync(lcd_vsync), .lcd_rgb(lcd_rgb)
   );

   assign dut_vec = {req_valid, req_x, req_y, frame_start, lcd_de, lcd_hsync, lcd_vsync, lcd_rgb};

   typedef struct packed {
      logic        v;
      logic [10:0] x;
      logic [9:0]  y;
      logic        fs;
      logic        hs;
      logic        vs;
   } req_t;

   req_t cur, prv, d1, d2;
   logic l1, l2, run;
   int   cnt, pos;
   int   vecs = 0, errs = 0;

   // what the raster should present at a given frame position
   function automatic req_t req_at(input logic r, input int p);
      req_t q;
      int h, v;
      h    = p % HT;
      v    = p / HT;
      q.v  = r && h < HA && v < VA;
      q.x  = q.v ? 11'(h) : '0;
      q.y  = q.v ? 10'(v) : '0;
      q.fs = r && p == 0;
      q.hs = r && h >= HA + HF && h < HA + HF + HS;
      q.vs = r && v >= VA + VF && v < VA + VF + VS;
      return q;
   endfunction

   function automatic logic [49:0] exp_vec();
      return {cur.v, cur.x, cur.y, cur.fs, d2.v, d2.hs ? HP : !HP, d2.vs ? VP : !VP,
              d2.v ? {3'b000, d2.y, d2.x} : 24'd0};
   endfunction

   // drive one clock of stimulus (renderer answers last cycle's request) and advance the model
   task automatic tick(input logic lk, input logic rs);
      pll_lock  = lk;
      reset     = rs;
      pixel_rgb = prv.v ? {3'b000, prv.y, prv.x} : 24'($urandom);
      @(posedge clk);
      prv = cur;
      if (rs) begin
         l1 = 0; l2 = 0; run = 0; cnt = 0; pos = 0; d1 = '0; d2 = '0;
      end else begin
         d2 = d1;
         d1 = cur;
         if (!run) begin
            cnt = l2 ? cnt + 1 : 0;
            if (cnt == LW) begin
               run = 1;
               cnt = 0;
            end
         end else if (!l2) begin
            run = 0;
            pos = 0;
         end else pos = (pos + 1) % FR;
         l2 = l1;
         l1 = lk;
      end
      cur = req_at(run, pos);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1, 1);
         vecs++;
         if (dut_vec !== RST_VEC) begin
            errs++;
            $display("FAIL reset: got %h want %h", dut_vec, RST_VEC);
         end
      end
   endtask

   task automatic test_startup();
      int n;
      tick(1, 1);
      n = 0;
      do begin
         tick(1, 0);
         n++;
      end while (!req_valid && n < 20);
      vecs++;
      if (n !== 6) begin
         errs++;
         $display("FAIL startup_latency: got %0d want 6", n);
      end
      vecs++;
      if ({req_x, req_y, frame_start} !== {11'd0, 10'd0, 1'b1}) begin
         errs++;
         $display("FAIL startup_first: got x=%0d y=%0d fs=%b want 0 0 1", req_x, req_y, frame_start);
      end
      vecs++;
      if (dut_vec !== exp_vec()) begin
         errs++;
         $display("FAIL startup_model: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_glitch();
      int n;
      tick(1, 1);
      tick(1, 0);
      tick(1, 0);
      tick(0, 0);
      n = 3;
      do begin
         tick(1, 0);
         n++;
      end while (!req_valid && n < 30);
      vecs++;
      if (n !== 9) begin
         errs++;
         $display("FAIL glitch_latency: got %0d want 9", n);
      end
      vecs++;
      if (dut_vec !== exp_vec()) begin
         errs++;
         $display("FAIL glitch_model: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_steady();
      int nval = 0, nfs = 0, nhs = 0;
      for (int i = 0; i < 2 * FR; i++) begin
         tick(1, 0);
         nval += int'(req_valid);
         nfs  += int'(frame_start);
         nhs  += int'(lcd_hsync == HP);
         vecs++;
         if (dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL steady_cycle%0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
      vecs++;
      if ({nval, nfs, nhs} !== {2 * HA * VA, 2, 2 * VT * HS}) begin
         errs++;
         $display("FAIL steady_counts: got valid=%0d fs=%0d hs=%0d want %0d 2 %0d",
                  nval, nfs, nhs, 2 * HA * VA, 2 * VT * HS);
      end
   endtask

   task automatic test_lock_drop();
      int n = 0;
      while (!(cur.v && cur.x == 11'd3) && n < 200) begin
         tick(1, 0);
         n++;
      end
      tick(0, 0);
      tick(1, 0);
      tick(1, 0);
      vecs++;
      if (req_valid !== 1'b0) begin
         errs++;
         $display("FAIL drop_valid: got %b want 0", req_valid);
      end
      n = 0;
      do begin
         tick(1, 0);
         n++;
         vecs++;
         if (dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL drop_model: got %h want %h", dut_vec, exp_vec());
         end
      end while (!frame_start && n < 20);
      vecs++;
      if ({n, req_x, req_y} !== {32'd4, 11'd0, 10'd0}) begin
         errs++;
         $display("FAIL drop_restart: got n=%0d x=%0d y=%0d want 4 0 0", n, req_x, req_y);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         tick($urandom_range(0, 31) != 0, $urandom_range(0, 199) == 0);
         vecs++;
         if (dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_mid_reset();
      int n = 0;
      while (!(cur.v && cur.x == 11'd5) && n < 200) begin
         tick(1, 0);
         n++;
      end
      tick(1, 1);
      vecs++;
      if (dut_vec !== RST_VEC) begin
         errs++;
         $display("FAIL mid_reset: got %h want %h", dut_vec, RST_VEC);
      end
      tick(1, 0);
      vecs++;
      if (dut_vec !== exp_vec()) begin
         errs++;
         $display("FAIL mid_reset_after: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   initial begin
      l1 = 0; l2 = 0; run = 0; cnt = 0; pos = 0;
      d1 = '0; d2 = '0; prv = '0;
      cur = req_at(0, 0);
      test_reset();
      test_startup();
      test_glitch();
      test_steady();
      test_lock_drop();
      test_random();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
